conv_result_collector: RTL and testbench

Sink for the convolution datapath's output stream. Accepts one 48-bit signed accumulator result per valid strobe and requantizes it to `OUT_W` bits by arithmetic shift and saturation. Stores results in row-major order into an internal output feature map buffer of `OUT_SIZE`×`OUT_SIZE` words, then raises `o_done` and serves random-access reads to the downstream layer or host. Sits directly after the conv block and closes its go/done handshake on the output side.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/ofm_buffer.sv | 27 ++
 rtl/conv_result_collector.sv | 80 ++++++++
 tb/tb_conv_result_collector.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, map-size derivation, FSM states and saturation classifier for the conv output side.
package conv_pkg;
  localparam int ACC_W = 48;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  typedef enum logic [1:0] {SAT_NONE, SAT_HI, SAT_LO, SAT_ZERO} sat_t;
  function automatic int out_size(input int fm, input int k, input int p, input int s);
    return (fm + 2*p - k) / s + 1;
  endfunction
  function automatic int map_words(input int fm, input int k, input int p, input int s);
    return out_size(fm, k, p, s) * out_size(fm, k, p, s);
  endfunction
  // Classifies a shifted accumulator against the signed out_w range; relu turns negatives into SAT_ZERO.
  function automatic sat_t sat_sel(input logic signed [ACC_W-1:0] s, input int out_w, input logic relu);
    logic [ACC_W-1:0] one;
    logic signed [ACC_W-1:0] hi;
    one = ACC_W'(1);
    hi = $signed((one << (out_w - 1)) - one);
    sat_sel = SAT_NONE;
    if (relu && s[ACC_W-1]) sat_sel = SAT_ZERO;
    else if (s > hi) sat_sel = SAT_HI;
    else if (s < ~hi) sat_sel = SAT_LO;
  endfunction
endpackage

// File: rtl/ofm_buffer.sv
// ofm_buffer: output feature map store, one write and one registered read-first read port per cycle.
module ofm_buffer #(
  parameter int DEPTH = 4,
  parameter int W = 16,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
    end
endmodule

// File: rtl/conv_result_collector.sv
// conv_result_collector: requantizes conv accumulator results into a row-major OFM buffer; CONV_RELU_EN clamps negatives to 0.
module conv_result_collector
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE = 4,
  parameter int PADDING = 0,
  parameter int STRIDE = 1,
  parameter int OUT_W = 16,
  parameter int FRAC_SHIFT = 0,
  localparam int N = map_words(FM_SIZE, KERNEL_SIZE, PADDING, STRIDE),
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_valid,
  input  logic signed [ACC_W-1:0] i_conv_result,
  input  logic                    i_rd_en,
  input  logic [ADDR_W-1:0]       i_rd_addr,
  output logic signed [OUT_W-1:0] o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_sat,
  output logic                    o_err
);
`ifdef CONV_RELU_EN
  localparam logic RELU = 1'b1;
`else
  localparam logic RELU = 1'b0;
`endif
  state_t state, state_nx;
  sat_t sel;
  logic [ADDR_W-1:0] wr_ptr;
  logic signed [ACC_W-1:0] shifted;
  logic [OUT_W-1:0] wr_data;
  logic wr_en;
  always_comb begin
    shifted = i_conv_result >>> FRAC_SHIFT;
    sel = sat_sel(shifted, OUT_W, RELU);
    wr_data = sel == SAT_HI ? {1'b0, {(OUT_W-1){1'b1}}} :
              sel == SAT_LO ? {1'b1, {(OUT_W-1){1'b0}}} :
              sel == SAT_ZERO ? '0 : shifted[OUT_W-1:0];
    wr_en = i_valid && !i_start && state == COLLECT;
    state_nx = i_start ? COLLECT :
               (wr_en && wr_ptr == ADDR_W'(N - 1)) ? DONE : state;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      o_sat <= 1'b0;
      o_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (i_start) begin
        wr_ptr <= '0;
        o_sat <= 1'b0;
        o_err <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (wr_en && (sel == SAT_HI || sel == SAT_LO)) o_sat <= 1'b1;
        if (i_valid && state != COLLECT) o_err <= 1'b1;
      end
    end
  assign o_busy = state == COLLECT;
  assign o_done = state == DONE;
  ofm_buffer #(.DEPTH(N), .W(OUT_W), .AW(ADDR_W)) u_buf (
    .clk(i_clk),
    .rst(i_rst),
    .wr_en(wr_en),
    .wr_addr(wr_ptr),
    .wr_data(wr_data),
    .rd_en(i_rd_en),
    .rd_addr(i_rd_addr),
    .rd_data(o_rd_data),
    .rd_valid(o_rd_valid)
  );
endmodule

// File: tb/tb_conv_result_collector.sv
// tb_conv_result_collector: randomized self-checking bench with a spec-level model of the collector.
module tb_conv_result_collector;
  localparam int N = 4;
  logic clk = 0, rst = 1, start = 0, valid = 0, rd_en = 0;
  logic [47:0] acc = '0;
  logic [1:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic rd_valid, busy, done, sat, err;
  logic start8 = 0, valid8 = 0, rd_en8 = 0;
  logic [47:0] acc8 = '0;
  logic [1:0] rd_addr8 = '0;
  logic [15:0] rd_data8;
  logic rd_valid8, busy8, done8, sat8, err8;
  int checks = 0, failures = 0;
  int m_mem[N];
  bit m_known[N];
  int m_ptr;
  bit m_busy, m_done, m_sat, m_err;
  logic [15:0] exp_rd;
  bit exp_known;

  always #5 clk = ~clk;

  conv_result_collector dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .i_conv_result(acc),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_busy(busy), .o_done(done), .o_sat(sat), .o_err(err)
  );
  conv_result_collector #(.FRAC_SHIFT(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_valid(valid8), .i_conv_result(acc8),
    .i_rd_en(rd_en8), .i_rd_addr(rd_addr8), .o_rd_data(rd_data8), .o_rd_valid(rd_valid8),
    .o_busy(busy8), .o_done(done8), .o_sat(sat8), .o_err(err8)
  );

  function automatic int rq(input longint v, input int sh, output bit s);
    longint x;
    x = v >>> sh;
    s = 0;
`ifdef CONV_RELU_EN
    if (x < 0) x = 0;
`endif
    if (x > 32767) begin x = 32767; s = 1; end
    else if (x < -32768) begin x = -32768; s = 1; end
    return int'(x);
  endfunction

  function automatic longint rnd();
    longint x;
    case ($urandom_range(0, 3))
      0: x = longint'($urandom_range(0, 2000)) - 1000;
      1: x = 32767 - 3 + longint'($urandom_range(0, 6));
      2: x = -32768 - 3 + longint'($urandom_range(0, 6));
      default: begin
        x = {$urandom, $urandom};
        x = (x <<< 16) >>> 16;
      end
    endcase
    return x;
  endfunction

  task automatic cyc(input bit st, input bit v, input longint d, input bit re, input int ra);
    int t;
    bit s;
    start = st; valid = v; acc = d[47:0]; rd_en = re; rd_addr = ra[1:0];
    t = m_mem[ra];
    exp_rd = t[15:0];
    exp_known = m_known[ra];
    @(negedge clk);
    if (st) begin
      m_ptr = 0; m_sat = 0; m_err = 0; m_busy = 1; m_done = 0;
    end else if (v) begin
      if (m_busy) begin
        m_mem[m_ptr] = rq(d, 0, s);
        m_known[m_ptr] = 1;
        m_sat |= s;
        m_ptr++;
        if (m_ptr == N) begin m_busy = 0; m_done = 1; end
      end else m_err = 1;
    end
    start = 0; valid = 0; rd_en = 0;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_busy = 0; m_done = 0; m_sat = 0; m_err = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    rd_en = 1;
    repeat (2) @(negedge clk);
    rd_en = 0;
    checks++;
    if ({busy, done, sat, err, rd_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {busy, done, sat, err, rd_valid});
    end
    checks++;
    if (rd_data !== 16'd0) begin failures++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
    rst = 0;
    model_reset();
  endtask

  task automatic test_basic();
    longint v[4] = '{100, -7, 0, 32767};
    cyc(1, 0, 0, 0, 0);
    checks++;
    if ({busy, done} !== 2'b10) begin failures++; $display("FAIL basic_busy got=%b exp=10", {busy, done}); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, v[i], 0, 0);
      checks++;
      if (done !== m_done) begin failures++; $display("FAIL basic_done[%0d] got=%b exp=%b", i, done, m_done); end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, i);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
        failures++;
        $display("FAIL basic_read[%0d] got=%0d/%b exp=%0d/1", i, $signed(rd_data), rd_valid, $signed(exp_rd));
      end
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (rd_valid !== 1'b0 || sat !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL basic_idle got=valid%b sat%b done%b exp=valid0 sat0 done1", rd_valid, sat, done);
    end
  endtask

  task automatic test_saturation();
    longint v[4];
    v = '{40000, -40000, rnd(), rnd()};
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, v[i], 0, 0);
    checks++;
    if (sat !== 1'b1 || sat !== m_sat) begin failures++; $display("FAIL sat_flag got=%b exp=1", sat); end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 1, i);
      checks++;
      if (rd_data !== exp_rd) begin
        failures++;
        $display("FAIL sat_read[%0d] got=%0d exp=%0d", i, $signed(rd_data), $signed(exp_rd));
      end
    end
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (sat !== 1'b0) begin failures++; $display("FAIL sat_clear got=%b exp=0", sat); end
  endtask

  task automatic test_random();
    for (int m = 0; m < 6; m++) begin
      cyc(1, 0, 0, $urandom_range(0, 1), $urandom_range(0, 3));
      while (!m_done) begin
        cyc(0, $urandom_range(0, 3) != 0, rnd(), 1, $urandom_range(0, 3));
        checks++;
        if ({busy, done, sat, err} !== {m_busy, m_done, m_sat, m_err}) begin
          failures++;
          $display("FAIL rand_status got=%b exp=%b", {busy, done, sat, err}, {m_busy, m_done, m_sat, m_err});
        end
        if (exp_known) begin
          checks++;
          if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
            failures++;
            $display("FAIL rand_read got=%0d exp=%0d", $signed(rd_data), $signed(exp_rd));
          end
        end
      end
    end
  endtask

  task automatic test_restart();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 77, 0, 0);
    cyc(0, 1, 88, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, i, 0, 0);
      checks++;
      if (done !== (i == 4)) begin failures++; $display("FAIL restart_done[%0d] got=%b exp=%b", i, done, i == 4); end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, i);
      checks++;
      if (rd_data !== 16'(i + 1)) begin
        failures++;
        $display("FAIL restart_read[%0d] got=%0d exp=%0d", i, $signed(rd_data), i + 1);
      end
    end
  endtask

  task automatic test_stray();
    cyc(0, 1, 999, 0, 0);
    checks++;
    if (err !== 1'b1 || done !== 1'b1) begin failures++; $display("FAIL stray_err got=err%b done%b exp=err1 done1", err, done); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, i);
      checks++;
      if (rd_data !== exp_rd) begin
        failures++;
        $display("FAIL stray_read[%0d] got=%0d exp=%0d", i, $signed(rd_data), $signed(exp_rd));
      end
    end
    cyc(1, 1, 555, 0, 0);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL start_valid got=err%b busy%b exp=err0 busy1", err, busy); end
    for (int i = 0; i < 3; i++) cyc(0, 1, 10 + i, 0, 0);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL start_valid_ignored got=done%b exp=0", done); end
    cyc(0, 1, 13, 0, 0);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL start_valid_fill got=done%b exp=1", done); end
  endtask

  task automatic test_read_first();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, -1234, 1, 0);
    checks++;
    if (rd_data !== 16'd10) begin failures++; $display("FAIL read_first got=%0d exp=10", $signed(rd_data)); end
    cyc(0, 0, 0, 1, 0);
    checks++;
    if (rd_data !== exp_rd) begin failures++; $display("FAIL read_after_write got=%0d exp=%0d", $signed(rd_data), $signed(exp_rd)); end
  endtask

  task automatic test_reset_mid();
    cyc(0, 1, 4321, 0, 0);
    rst = 1;
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
    checks++;
    if ({busy, done, sat, err, rd_valid} !== 5'b0 || rd_data !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset got=%b/%0d exp=00000/0", {busy, done, sat, err, rd_valid}, $signed(rd_data));
    end
    rst = 0;
    model_reset();
    cyc(0, 1, 55, 0, 0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL no_start_err got=err%b busy%b exp=err1 busy0", err, busy); end
  endtask

  task automatic test_frac8();
    longint v[4];
    int e;
    bit s;
    v = '{65664, -1, rnd(), rnd()};
    start8 = 1; @(negedge clk); start8 = 0;
    for (int i = 0; i < 4; i++) begin
      valid8 = 1; acc8 = v[i][47:0]; @(negedge clk); valid8 = 0;
    end
    checks++;
    if (done8 !== 1'b1) begin failures++; $display("FAIL frac8_done got=%b exp=1", done8); end
    for (int i = 0; i < 4; i++) begin
      rd_en8 = 1; rd_addr8 = 2'(i); @(negedge clk); rd_en8 = 0;
      e = rq(v[i], 8, s);
      checks++;
      if (rd_data8 !== e[15:0]) begin failures++; $display("FAIL frac8_read[%0d] got=%0d exp=%0d", i, $signed(rd_data8), e); end
    end
  endtask

`ifdef CONV_RELU_EN
  task automatic test_relu();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, -5, 0, 0);
    cyc(0, 0, 0, 1, 0);
    checks++;
    if (rd_data !== 16'd0 || sat !== 1'b0) begin failures++; $display("FAIL relu_neg got=%0d sat%b exp=0 sat0", $signed(rd_data), sat); end
    cyc(0, 1, 40000, 0, 0);
    cyc(0, 0, 0, 1, 1);
    checks++;
    if (rd_data !== 16'd32767 || sat !== 1'b1) begin failures++; $display("FAIL relu_pos got=%0d sat%b exp=32767 sat1", $signed(rd_data), sat); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_random();
    test_restart();
    test_stray();
    test_read_first();
    test_reset_mid();
    test_frac8();
`ifdef CONV_RELU_EN
    test_relu();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
